// File: rtl/fp_pkg.sv
// Shared floating-point constants, FSM state and float class types.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int FLAG_NAN = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_INX = 0;

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_t;

endpackage

// File: rtl/fp_to_int_seq_unpack.sv
// Combinational IEEE single unpacker: fields, implicit bit, class, unbiased exponent.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]              f,
  output logic                     sign,
  output logic [MAN_W:0]           mant,
  output logic [MAN_W-1:0]         frac,
  output logic [2:0]               cls,
  output logic signed [EXP_W+1:0]  exp_unb
);

  logic [EXP_W-1:0] e;

  assign sign    = f[31];
  assign e       = f[30:23];
  assign frac    = f[MAN_W-1:0];
  assign mant    = {(e != '0), frac};
  assign exp_unb = $signed({2'b00, e}) - $signed((EXP_W+2)'(BIAS));

  always_comb begin
    if (e == '0) begin
      cls = (frac == '0) ? ZERO : DENORM;
    end else if (e == EXP_W'(EXP_MAX)) begin
      cls = (frac == '0) ? INF : NAN;
    end else begin
      cls = NORMAL;
    end
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// Sequential float-to-int converter, one shift bit per cycle, valid/ready on both sides.
// Define FP2INT_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_to_int_seq
  import fp_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_flags
);

  localparam int W = (OUT_W > 24) ? OUT_W : 24;
  localparam logic signed [9:0] E_TOP = 10'(OUT_W - 1);
  localparam logic signed [9:0] E_PIV = 10'sd23;
  localparam logic [OUT_W-1:0]  INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  INT_MAX = ~INT_MIN;
`ifdef FP2INT_ROUND_EN
  localparam logic signed [9:0] E_HALF = -10'sd1;
`endif

  logic               u_sign;
  logic [MAN_W:0]     u_mant;
  logic [MAN_W-1:0]   u_frac;
  logic [2:0]         u_cls_raw;
  fp_class_t          u_cls;
  logic signed [9:0]  u_exp;

  fp_unpack u_unpack (
    .f       (in_data),
    .sign    (u_sign),
    .mant    (u_mant),
    .frac    (u_frac),
    .cls     (u_cls_raw),
    .exp_unb (u_exp)
  );

  assign u_cls = fp_class_t'(u_cls_raw);

  state_t             state_reg, state_next;
  logic               sign_reg;
  fp_class_t          cls_reg;
  logic signed [9:0]  exp_reg;
  logic               frac_nz_reg;
  logic [W-1:0]       mag_reg;
  logic               guard_reg, sticky_reg;
  logic [4:0]         cnt_reg;
  logic               left_reg;
  logic [OUT_W-1:0]   out_data_reg;
  logic [2:0]         out_flags_reg;

  logic               accept;
  logic               in_range;
  logic [4:0]         shift_n;
  logic [OUT_W-1:0]   mag_fin, sat_val, fix_data;
  logic [2:0]         fix_flags;
  logic               carry_ovf;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_data_reg;
  assign out_flags = out_flags_reg;
  assign accept    = in_valid && in_ready;

  // Only normal values that end up representable go through the shifter.
  assign in_range = (u_cls == NORMAL) && !u_exp[9] && (u_exp < E_TOP);
  always_comb begin
    shift_n = 5'd0;
    if (in_range) begin
      shift_n = (u_exp > E_PIV) ? 5'(u_exp - E_PIV) : 5'(E_PIV - u_exp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = (shift_n != 5'd0) ? SHIFT : FIX;
      SHIFT: if (cnt_reg == 5'd1) state_next = FIX;
      FIX:   state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg      <= 1'b0;
      cls_reg       <= ZERO;
      exp_reg       <= '0;
      frac_nz_reg   <= 1'b0;
      mag_reg       <= '0;
      guard_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
      cnt_reg       <= '0;
      left_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_flags_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          sign_reg    <= u_sign;
          cls_reg     <= u_cls;
          exp_reg     <= u_exp;
          frac_nz_reg <= |u_frac;
          mag_reg     <= W'(u_mant);
          guard_reg   <= 1'b0;
          sticky_reg  <= 1'b0;
          cnt_reg     <= shift_n;
          left_reg    <= (u_exp > E_PIV);
        end
        SHIFT: begin
          cnt_reg <= cnt_reg - 5'd1;
          if (left_reg) begin
            mag_reg <= mag_reg << 1;
          end else begin
            mag_reg    <= mag_reg >> 1;
            guard_reg  <= mag_reg[0];
            sticky_reg <= sticky_reg | guard_reg;
          end
        end
        FIX: begin
          out_data_reg  <= fix_data;
          out_flags_reg <= fix_flags;
        end
        default: ;
      endcase
    end
  end

  assign sat_val = sign_reg ? INT_MIN : INT_MAX;

  always_comb begin
    mag_fin   = mag_reg[OUT_W-1:0];
    carry_ovf = 1'b0;
`ifdef FP2INT_ROUND_EN
    if (guard_reg & (sticky_reg | mag_reg[0])) mag_fin = mag_reg[OUT_W-1:0] + OUT_W'(1);
    // A carry into the sign bit is only representable for negative results.
    carry_ovf = ~sign_reg & mag_fin[OUT_W-1];
`endif
    fix_data  = '0;
    fix_flags = '0;
    case (cls_reg)
      DENORM: fix_flags[FLAG_INX] = 1'b1;
      NAN:    fix_flags[FLAG_NAN] = 1'b1;
      INF: begin
        fix_data            = sat_val;
        fix_flags[FLAG_OVF] = 1'b1;
      end
      NORMAL: begin
        if (exp_reg >= E_TOP) begin
          if (sign_reg && (exp_reg == E_TOP) && !frac_nz_reg) begin
            fix_data = INT_MIN;
          end else begin
            fix_data            = sat_val;
            fix_flags[FLAG_OVF] = 1'b1;
          end
        end else if (exp_reg[9]) begin
          fix_flags[FLAG_INX] = 1'b1;
`ifdef FP2INT_ROUND_EN
          if ((exp_reg == E_HALF) && frac_nz_reg) fix_data = sign_reg ? '1 : OUT_W'(1);
`endif
        end else if (carry_ovf) begin
          fix_data            = sat_val;
          fix_flags[FLAG_OVF] = 1'b1;
        end else begin
          fix_data            = sign_reg ? -mag_fin : mag_fin;
          fix_flags[FLAG_INX] = guard_reg | sticky_reg;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fp_to_int_seq.md
# fp_to_int_seq

Multi-cycle converter from IEEE-754 single-precision to a signed two's-complement integer. It sits directly downstream of the floating-point adder and consumes the adder's 32-bit `out` word, producing an integer suitable for the display and counter logic. Conversion uses an iterative one-bit-per-cycle shifter with valid/ready handshakes on both sides.

## Interface
- `OUT_W`, default 32: output integer width; legal range 8..32.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a float to convert.
- `in_ready`  out  1  block is idle and can accept a float.
- `in_data`  in  32  IEEE single: sign [31], exponent [30:23], fraction [22:0].
- `out_valid`  out  1  `out_data` and `out_flags` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  OUT_W  signed integer result.
- `out_flags`  out  3  [2] nan, [1] overflow, [0] inexact.

## Operation
- FSM states: IDLE, SHIFT, FIX, DONE.
- **IDLE**: `in_ready`=1. On `in_valid && in_ready`, latch the sign, exponent e and mantissa m, then classify:
  - m = {1, frac} if e≠0; e=0 gives magnitude 0.
  - Unbiased exponent E = e−127.
  - n = |E−23| for normal in-range values, else 0.
  - Next state is SHIFT if n>0, else FIX.
- **SHIFT**: one bit per cycle over n cycles.
  - E>23: shift left.
  - E<23: shift right, with guard = last bit shifted out and sticky = OR of all earlier shifted-out bits.
  - Working magnitude register is max(OUT_W,24) bits, unsigned.
- **FIX** (one cycle): apply rounding, range check and sign, register `out_data`/`out_flags`, then go to DONE.
- **DONE**: `out_valid`=1 and outputs are held stable until `out_ready`, then return to IDLE. The next accept cannot occur in the handshake cycle.
- Classification and results:
  - **Zero or −0**: result 0, flags 0.
  - **Denormal** (e=0, frac≠0): result 0, inexact=1.
  - **NaN** (e=255, frac≠0): result 0, nan=1.
  - **±Inf**: saturate to +2^(OUT_W−1)−1 or −2^(OUT_W−1); overflow=1.
  - **E ≥ OUT_W−1**: saturate as for Inf, overflow=1. The one exception is the exact value −2^(OUT_W−1) (sign=1, E=OUT_W−1, frac=0), which returns that value with flags 0.
  - **E < 0**: magnitude 0 (rounding exceptions under Configuration); inexact=1.
  - **0 ≤ E ≤ OUT_W−2**: shift path; inexact = guard|sticky.
- Rounding carry: if it yields magnitude 2^(OUT_W−1), positive values saturate with overflow=1 and inexact=0; the negative value is representable.
- When nan or overflow is set, inexact=0.
- Negation is two's complement of the final magnitude in OUT_W bits.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_flags`=0.
- Latency: the accept edge is cycle 0. `out_valid` rises n+2 cycles later (n SHIFT cycles + FIX).
  - Maximum latency is 25 (E=−0 path excluded, since E<0 takes n=0).
  - Special cases take 2 cycles.
- `in_ready` is 0 from the accept edge until one cycle after the output handshake. `in_valid` during this time is ignored.
- `rst` in any state aborts the conversion. The next cycle is IDLE with reset values and no result emitted.

## Configuration
- `FP2INT_ROUND_EN` defined: FIX rounds to nearest, ties to even.
  - Increment when guard & (sticky | lsb).
  - For E=−1: result magnitude 1 if frac≠0, else 0 (0.5 rounds to even 0).
  - E<−1 still yields 0.
- `FP2INT_ROUND_EN` undefined: truncate toward zero and no rounding logic is built.
- inexact semantics are identical in both builds.

## Structure
- Package `fp_pkg`: constants EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=255; FSM state enum; flag bit indices FLAG_NAN=2, FLAG_OVF=1, FLAG_INX=0; float class enum (ZERO, DENORM, NORMAL, INF, NAN).
- One sub-module `fp_unpack`: combinational field split, implicit-bit insertion, class, and unbiased exponent. It is shared with future FP consumers.

## Test plan
- 0x40490FDB (3.14159) → `out_data`=3, flags=001; `out_valid` exactly 24 cycles after the accept.
- 0xC2F60000 (−123.0) → 0xFFFFFF85, flags=000, latency 19.
- OUT_W=32:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, flags=010.
  - 0xCF000000 → 0x80000000, flags=000.
  - 0x7FC00000 → 0, flags=100.
  - 0xFF800000 → 0x80000000, flags=010.
- Rounding, truncate build vs `FP2INT_ROUND_EN` build, inexact=1 in all cases:
  - 0x40200000 (2.5) → 2 vs 2.
  - 0x40600000 (3.5) → 3 vs 4.
  - 0x3F400000 (0.75) → 0 vs 1.
  - 0x3F000000 (0.5) → 0 vs 0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_data`/`out_flags` stable, `in_ready`=0, and a concurrent `in_valid` is not accepted. After the handshake, `in_ready`=1 on the next cycle.
- Assert `rst` during SHIFT of 0x40490FDB → the next cycle has `out_valid`=0 and `in_ready`=1. The next accepted 0x3F800000 returns 1, flags=000.
